// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, the NOP encoding
// and the RV32 major opcodes that control_unit decodes.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/instr_fetch_unit.sv
// Purpose: single-outstanding instruction fetch with redirect, feeding decode.
// Latency: request accept -> response >= 1 cycle -> instruction held the cycle after the response.
// Backpressure: imem_req_ready stalls REQ with a stable address; instr_ready holds the instruction.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            capture;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            fault_q;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    if (redirect_valid) begin
                        pc_d   = redirect_target;
                        drop_d = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    // A response in the redirect cycle retires the request, so
                    // nothing is left to drop and we can refetch immediately.
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC_ALIGNED;
            drop_q     <= 1'b0;
            instr_q    <= XLEN'(NOP_INSTR);
            instr_pc_q <= RESET_PC_ALIGNED;
            fault_q    <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
            if (capture) begin
                instr_q    <= imem_rsp_data;
                instr_pc_q <= pc_q;
                fault_q    <= imem_rsp_err;
            end
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_fault    = fault_q;
    assign opcode         = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7_5       = instr_q[30];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter XLEN, default 32: PC and instruction width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory is valid.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  memory returns instruction data this cycle.
REQ-009 imem_rsp_data  input  XLEN  returned instruction word.
REQ-010 imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid.
REQ-011 redirect_valid  input  1  taken branch/jal/jalr from execute; one-cycle pulse.
REQ-012 redirect_pc  input  XLEN  redirect target; bits [1:0] ignored.
REQ-013 instr_valid  output  1  instruction presented to decode/control unit.
REQ-014 instr_ready  input  1  decode consumes the instruction.
REQ-015 instr  output  XLEN  held instruction word.
REQ-016 instr_pc  output  XLEN  PC of the held instruction.
REQ-017 opcode / funct3 / funct7_5  output  7/3/1  instr[6:0], instr[14:12], instr[30], feeding control_unit.
REQ-018 fetch_fault  output  1  held instruction came from an errored response.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, HOLD; IDLE -> REQ unconditionally on the first cycle after reset release.
REQ-020 REQ: imem_req_valid=1, imem_req_addr=pc; on valid&&ready -> WAIT, else remain in REQ with address stable.
REQ-021 WAIT: on imem_rsp_valid, capture data/err into the output register -> HOLD; earliest response is the cycle after acceptance.
REQ-022 HOLD: instr_valid=1, outputs stable until instr_valid&&instr_ready; then pc <= pc+4 (mod 2^32) -> REQ.
REQ-023 pc bits [1:0] always 0; redirect_pc[1:0] forced to 0.
REQ-024 Redirect in REQ without handshake: pc <= redirect_pc, stay in REQ; new address driven next cycle.
REQ-025 Redirect in the same cycle as request handshake: pc <= redirect_pc, set drop flag -> WAIT.
REQ-026 Redirect in WAIT: pc <= redirect_pc, set drop flag; a response arriving in that same cycle is discarded.
REQ-027 WAIT with drop flag set: response discarded, flag cleared -> REQ (no HOLD).
REQ-028 Redirect in HOLD: held instruction dropped (instr_valid=0 next cycle, even if instr_ready was high) -> REQ with redirect_pc.
REQ-029 Redirect in IDLE: pc <= redirect_pc -> REQ.
REQ-030 At most one outstanding memory request; imem_req_valid=0 in WAIT and HOLD.
REQ-031 imem_rsp_valid outside WAIT is ignored.
REQ-032 fetch_fault=imem_rsp_err captured with the instruction; a faulted instruction is still presented and handshaken normally.
REQ-033 opcode/funct3/funct7_5 are combinational slices of the instr register.

Reset
REQ-034 On rst_n low: state=IDLE, pc=RESET_PC, drop flag=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, fetch_fault=0, instr_valid=0, imem_req_valid=0.
REQ-035 Reset asserted mid-transaction abandons the outstanding request; any later response is ignored until a new request is accepted.

Structure
REQ-036 Shared package holds the FSM state enum, NOP_INSTR constant (32'h0000_0013) and opcode constants shared with control_unit.
REQ-037 No sub-module; single module with an FSM plus pc/instruction registers.

Verification
REQ-038 Reset, ready=1, rsp one cycle after accept, instr_ready=1: addresses 0x0, 0x4, 0x8 issued; one instruction per 3 cycles; instr_pc matches.
REQ-039 imem_req_ready low 4 cycles in REQ: imem_req_addr held at 0x4, no state advance; instruction at 0x4 delivered after ready.
REQ-040 Redirect to 0x103 during WAIT at pc 0x8: response for 0x8 discarded, next request addr 0x100, instr_pc=0x100.
REQ-041 Redirect to 0x200 in HOLD with instr_ready=1 same cycle: instruction not consumed, next request addr 0x200.
REQ-042 imem_rsp_err=1 with data 0x00000033: instr_valid=1, fetch_fault=1, opcode=0110011, funct3=000, funct7_5=0.
REQ-043 rst_n pulsed low in WAIT, stale rsp returned afterwards: ignored; first request after reset at RESET_PC.
